// File: rtl/buf_scan_reader_pkg.sv
// Shared display definitions: scan FSM states, buffer address width and the
// pixel word carried through the output FIFO.
package buf_scan_reader_pkg;

  localparam int unsigned ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_word_t;

endpackage

// File: rtl/buf_scan_reader_pix_fifo.sv
// Small synchronous FIFO with occupancy count and a flush that empties it in
// one cycle. The head word reads as zero while the FIFO is empty.
module pix_fifo #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards all stored words.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/buf_scan_reader.sv
// Frame-buffer scan reader: walks the buffer in raster order, tags each pixel
// with start/end-of-line/end-of-frame flags and streams it through a skid FIFO
// under a valid/ready handshake.
module buf_scan_reader
  import buf_scan_reader_pkg::*;
#(
  parameter int unsigned H_PIXELS   = 100,
  parameter int unsigned V_LINES    = 100,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_r,
  input  logic [7:0]        rd_g,
  input  logic [7:0]        rd_b,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int unsigned FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam int unsigned COL_W        = $clog2(H_PIXELS + 1);
  localparam int unsigned LINE_W       = $clog2(V_LINES + 1);
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(H_PIXELS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(V_LINES - 1);
  localparam logic [CNT_W:0]    DEPTH_LIMIT = (CNT_W+1)'(FIFO_DEPTH);

  scan_state_t state;
  scan_state_t state_next;

  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;

  logic       issue_sof;
  logic       issue_eol;
  logic       issue_eof;
  logic       inflight;
  logic [2:0] inflight_flags;

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   occupancy;
  logic             fifo_empty;
  logic             room;
  logic             xfer;
  logic             eof_xfer;
  pix_word_t        push_word;
  pix_word_t        head_word;

  // Flags are derived from the raster counters at issue time, then carried
  // alongside the read for one cycle until the buffer data arrives.
  assign issue_sof = (addr == '0);
  assign issue_eol = (col == LAST_COL);
  assign issue_eof = issue_eol && (line == LAST_LINE);

  // Words already in the FIFO plus the read still in flight must leave a slot.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign room      = (occupancy < DEPTH_LIMIT);

  assign pix_valid = !fifo_empty;
  assign xfer      = pix_valid && pix_ready;
  assign eof_xfer  = xfer && head_word.eof;

  assign rd_addr = addr;
  assign pix_r   = head_word.r;
  assign pix_g   = head_word.g;
  assign pix_b   = head_word.b;
  assign pix_sof = head_word.sof;
  assign pix_eol = head_word.eol;
  assign pix_eof = head_word.eof;

  assign push_word = '{r: rd_r, g: rd_g, b: rd_b,
                       sof: inflight_flags[2], eol: inflight_flags[1],
                       eof: inflight_flags[0]};

  pix_fifo #(
    .WIDTH ($bits(pix_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort && busy),
    .push      (inflight),
    .push_data (push_word),
    .pop       (xfer),
    .pop_data  (head_word),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort outranks start and frame completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !abort) state_next = SCAN;
      SCAN:    if (abort) state_next = IDLE;
               else if (rd_en && (addr == LAST_ADDR)) state_next = DRAIN;
      DRAIN:   if (abort || eof_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy flag and flow-controlled read enable.
  always_comb begin
    busy  = (state != IDLE);
    rd_en = (state == SCAN) && !abort && room;
  end

  // Raster address, column and line counters; cleared whenever the scan ends.
  always_ff @(posedge clk) begin
    if (reset || state_next == IDLE) begin
      addr <= '0;
      col  <= '0;
      line <= '0;
    end else if (rd_en) begin
      addr <= addr + 1'b1;
      if (col == LAST_COL) begin
        col  <= '0;
        line <= line + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // In-flight read tracking and the done strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight       <= 1'b0;
      inflight_flags <= '0;
      done           <= 1'b0;
    end else begin
      inflight       <= rd_en;
      inflight_flags <= rd_en ? {issue_sof, issue_eol, issue_eof} : 3'b000;
      done           <= (state == DRAIN) && eof_xfer && !abort;
    end
  end

endmodule

// File: tb/tb_buf_scan_reader.sv
// Scoreboard bench for buf_scan_reader: a small 4x2 instance and a default
// 100x100 instance share control inputs, gated by a select bit.
module tb_buf_scan_reader;

  localparam int unsigned SH = 4, SV = 2, LH = 100, LV = 100, DEPTH = 4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, pix_ready, sel;
  int   ready_mode;

  // per-instance signals
  logic        busy_s, done_s, rd_en_s, pv_s, sof_s, eol_s, eof_s;
  logic [19:0] rd_addr_s;
  logic [7:0]  rd_r_s, rd_g_s, rd_b_s, pr_s, pg_s, pb_s;
  logic        busy_l, done_l, rd_en_l, pv_l, sof_l, eol_l, eof_l;
  logic [19:0] rd_addr_l;
  logic [7:0]  rd_r_l, rd_g_l, rd_b_l, pr_l, pg_l, pb_l;

  buf_scan_reader #(.H_PIXELS(SH), .V_LINES(SV), .FIFO_DEPTH(DEPTH)) dut_s (
    .clk(clk), .reset(reset), .start(start & ~sel), .abort(abort & ~sel),
    .busy(busy_s), .done(done_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s),
    .rd_r(rd_r_s), .rd_g(rd_g_s), .rd_b(rd_b_s),
    .pix_valid(pv_s), .pix_ready(pix_ready),
    .pix_r(pr_s), .pix_g(pg_s), .pix_b(pb_s),
    .pix_sof(sof_s), .pix_eol(eol_s), .pix_eof(eof_s));

  buf_scan_reader #(.H_PIXELS(LH), .V_LINES(LV), .FIFO_DEPTH(DEPTH)) dut_l (
    .clk(clk), .reset(reset), .start(start & sel), .abort(abort & sel),
    .busy(busy_l), .done(done_l), .rd_en(rd_en_l), .rd_addr(rd_addr_l),
    .rd_r(rd_r_l), .rd_g(rd_g_l), .rd_b(rd_b_l),
    .pix_valid(pv_l), .pix_ready(pix_ready),
    .pix_r(pr_l), .pix_g(pg_l), .pix_b(pb_l),
    .pix_sof(sof_l), .pix_eol(eol_l), .pix_eof(eof_l));

  // Observed outputs of the selected instance.
  logic        busy, done, rd_en, pv;
  logic [19:0] rd_addr;
  pix_t        pix;
  always_comb begin
    if (sel) begin
      busy = busy_l; done = done_l; rd_en = rd_en_l; pv = pv_l; rd_addr = rd_addr_l;
      pix  = '{r: pr_l, g: pg_l, b: pb_l, sof: sof_l, eol: eol_l, eof: eof_l};
    end else begin
      busy = busy_s; done = done_s; rd_en = rd_en_s; pv = pv_s; rd_addr = rd_addr_s;
      pix  = '{r: pr_s, g: pg_s, b: pb_s, sof: sof_s, eol: eol_s, eof: eof_s};
    end
  end

  // Preloaded frame buffer contents as a function of address.
  function automatic logic [23:0] buf_word(input logic [19:0] a);
    return {a[7:0], a[15:8], a[7:0] ^ a[19:12] ^ 8'h5A};
  endfunction

  // Buffer read port: data one cycle after rd_en, junk otherwise.
  always @(posedge clk) begin
    {rd_r_s, rd_g_s, rd_b_s} <= rd_en_s ? buf_word(rd_addr_s) : 24'($urandom);
    {rd_r_l, rd_g_l, rd_b_l} <= rd_en_l ? buf_word(rd_addr_l) : 24'($urandom);
  end

  // Reference: the k-th pixel of an h-wide, n-pixel frame.
  function automatic pix_t model_pixel(input int unsigned k, input int unsigned h,
                                       input int unsigned n);
    logic [19:0] a;
    pix_t p;
    a = k[19:0];
    p.r = buf_word(a)[23:16];
    p.g = buf_word(a)[15:8];
    p.b = buf_word(a)[7:0];
    p.sof = (k == 0);
    p.eol = ((k % h) == h - 1);
    p.eof = (k == n - 1);
    return p;
  endfunction

  int unsigned n_cmp = 0, n_fail = 0;
  pix_t        exp_q[$];
  int unsigned n_issued, n_accepted, exp_addr, n_dones;
  int unsigned frame_n, frame_h;
  bit          model_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares everything the DUT presents against the scoreboard.
  bit   rst_prev = 0, abort_prev = 0, stall_prev = 0, eof_prev = 0;
  pix_t prev_pix;
  initial n_dones = 0;
  always @(negedge clk) begin
    bit eof_now;
    eof_now = 0;
    if (rst_prev)
      chk("reset_values", {busy, done, rd_en, pv, pix, rd_addr}, '0);
    if (abort_prev)
      chk("abort_idle", {busy, pv, rd_en, done}, '0);
    if (done || eof_prev) begin
      chk("done_pulse", done, eof_prev);
      if (done) n_dones++;
    end
    if (reset || abort) begin
      if (abort && !reset) chk("rd_en_on_abort", rd_en, 0);
      exp_q.delete();
      n_issued = 0; n_accepted = 0; exp_addr = 0;
      model_busy = 0; stall_prev = 0;
    end else begin
      if (stall_prev) chk("hold_stable", {pv, pix}, {1'b1, prev_pix});
      if (rd_en) begin
        chk("rd_en_in_frame", n_issued < frame_n, 1);
        chk("rd_addr", rd_addr, exp_addr);
        exp_addr++;
        n_issued++;
        chk("outstanding", (n_issued - n_accepted) <= DEPTH, 1);
      end
      if (pv && pix_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pixel", pix, '1);
        else chk("pixel", pix, exp_q.pop_front());
        n_accepted++;
        eof_now = pix.eof;
        if (pix.eof) model_busy = 0;
      end
      stall_prev = pv && !pix_ready;
      prev_pix   = pix;
    end
    eof_prev   = eof_now && !reset && !abort;
    rst_prev   = reset;
    abort_prev = abort && !reset;
  end

  // Ready generator: 0 = always ready, 1 = random 50%, 2 = held low.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      pix_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue a start pulse; an idle model expects a full frame.
  task automatic start_frame();
    if (!model_busy) begin
      n_issued = 0; n_accepted = 0; exp_addr = 0;
      for (int unsigned k = 0; k < frame_n; k++) exp_q.push_back(model_pixel(k, frame_h, frame_n));
      model_busy = 1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned d0;
    d0 = n_dones;
    for (int unsigned c = 0; c < limit && n_dones == d0; c++) tick();
    chk("done_count", n_dones - d0, 1);
  endtask

  task automatic wait_accepted(input int unsigned target, input int unsigned limit);
    int unsigned c;
    for (c = 0; c < limit && n_accepted < target; c++) tick();
    chk("accept_budget", n_accepted >= target, 1);
  endtask

  task automatic wait_issued(input int unsigned target, input int unsigned limit);
    int unsigned c;
    for (c = 0; c < limit && n_issued < target; c++) tick();
    chk("issue_budget", n_issued >= target, 1);
  endtask

  initial begin
    int unsigned d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; ready_mode = 0;
    frame_n = SH * SV; frame_h = SH;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Small frame, ready high: latency to first valid, data and flags, done.
    start_frame();
    @(negedge clk); chk("latency_c1", pv, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("latency_c2", pv, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("latency_c3", pv, 1);
    @(posedge clk); #1;
    wait_done(100);
    tick(3);

    // Mid-frame stall: reads stop with the FIFO plus in-flight at capacity.
    start_frame();
    wait_accepted(2, 50);
    ready_mode = 2;
    tick(10);
    chk("stall_rd_en_off", rd_en, 0);
    chk("stall_outstanding", n_issued - n_accepted, DEPTH);
    ready_mode = 0;
    wait_done(100);
    tick(3);

    // Start pulses while busy are ignored.
    d0 = n_dones;
    start_frame();
    tick(3);
    start_frame();
    tick(2);
    start_frame();
    wait_done(100);
    tick(20);
    chk("no_second_frame", {busy, pv}, 0);
    chk("single_done", n_dones - d0, 1);
    chk("queue_empty_s", exp_q.size(), 0);

    // Reset while draining: reset values next cycle, no done afterwards.
    start_frame();
    wait_issued(frame_n, 50);
    ready_mode = 2;
    tick(2);
    chk("in_drain_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready_mode = 0;
    d0 = n_dones;
    tick(10);
    chk("no_done_after_reset", n_dones, d0);

    // Full 100x100 frame with random backpressure.
    sel = 1'b1; frame_n = LH * LV; frame_h = LH;
    ready_mode = 1;
    tick(2);
    start_frame();
    wait_done(60000);
    chk("all_pixels_random", n_accepted, LH * LV);
    chk("queue_empty_l", exp_q.size(), 0);
    tick(3);

    // Abort around pixel 37, then a fresh scan from address 0.
    start_frame();
    wait_accepted(37, 500);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    d0 = n_dones;
    tick(5);
    chk("abort_no_done", n_dones, d0);
    chk("abort_pv_low", pv, 0);
    ready_mode = 0;
    start_frame();
    wait_done(12000);
    chk("all_pixels_rescan", n_accepted, LH * LV);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
